// File: rtl/otf_digit_converter_if.sv
// Handshake bundle between the online divider's digit stream and the on-the-fly converter.
// The master side drives digits and start; the slave side is the converter.
interface otf_digit_converter_if #(
    parameter int Num_bits = 4
);
    logic                start;
    logic                digit_valid;
    logic [1:0]          digit_select;
    logic                busy;
    logic                result_valid;
    logic [Num_bits:0]   result;
    logic                digit_err;

    modport master (
        output start, digit_valid, digit_select,
        input  busy, result_valid, result, digit_err
    );

    modport slave (
        input  start, digit_valid, digit_select,
        output busy, result_valid, result, digit_err
    );
endinterface

// File: rtl/otf_digit_converter.sv
// On-the-fly conversion of an MSB-first radix-2 signed-digit string into two's complement.
// Keeps Q and QM = Q-1 so every digit is absorbed by a shift/select, never a carry chain.
module otf_digit_converter #(
    parameter int Num_bits = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    otf_digit_converter_if.slave  bus
);
    localparam int W  = Num_bits + 1;
    localparam int CW = $clog2(Num_bits) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(Num_bits - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_r, state_s;
    logic [W-1:0]   q_r, q_s;
    logic [W-1:0]   qm_r, qm_s;
    logic [CW-1:0]  count_r, count_s;
    logic           err_r, err_s;
    logic [W-1:0]   result_r, result_s;
    logic           busy_r, busy_s;
    logic           valid_r, valid_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, digit absorption and next output values
    always_comb begin
        state_s  = state_r;
        q_s      = q_r;
        qm_s     = qm_r;
        count_s  = count_r;
        err_s    = err_r;
        result_s = result_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                    q_s     = {W{1'b0}};
                    qm_s    = {W{1'b1}};
                    count_s = {CW{1'b0}};
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (bus.start) begin
                    // Restart wins over any digit presented in the same cycle
                    q_s     = {W{1'b0}};
                    qm_s    = {W{1'b1}};
                    count_s = {CW{1'b0}};
                    err_s   = 1'b0;
                end else if (bus.digit_valid) begin
                    case (bus.digit_select)
                        2'b10: begin
                            q_s  = {q_r[W-2:0], 1'b1};
                            qm_s = {q_r[W-2:0], 1'b0};
                        end
                        2'b01: begin
                            q_s  = {qm_r[W-2:0], 1'b1};
                            qm_s = {qm_r[W-2:0], 1'b0};
                        end
                        2'b11: begin
                            q_s   = {q_r[W-2:0], 1'b0};
                            qm_s  = {qm_r[W-2:0], 1'b1};
                            err_s = 1'b1;
                        end
                        default: begin
                            q_s  = {q_r[W-2:0], 1'b0};
                            qm_s = {qm_r[W-2:0], 1'b1};
                        end
                    endcase
                    count_s = count_r + CW'(1);
                    if (count_r == LAST_CNT) begin
                        state_s  = DONE;
                        result_s = q_s;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_s = RUN;
                    q_s     = {W{1'b0}};
                    qm_s    = {W{1'b1}};
                    count_s = {CW{1'b0}};
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s  = (state_s == RUN);
        valid_s = (state_s == DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r      <= {W{1'b0}};
            qm_r     <= {W{1'b1}};
            count_r  <= {CW{1'b0}};
            err_r    <= 1'b0;
            result_r <= {W{1'b0}};
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            q_r      <= q_s;
            qm_r     <= qm_s;
            count_r  <= count_s;
            err_r    <= err_s;
            result_r <= result_s;
            busy_r   <= busy_s;
            valid_r  <= valid_s;
        end
    end

    assign bus.busy         = busy_r;
    assign bus.result_valid = valid_r;
    assign bus.result       = result_r;
    assign bus.digit_err    = err_r;
endmodule

// File: tb/tb_otf_digit_converter.sv
// Directed, table-driven bench for otf_digit_converter with Num_bits = 4.
module tb_otf_digit_converter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    otf_digit_converter_if #(.Num_bits(4)) bus_if ();

    otf_digit_converter #(.Num_bits(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct {
        logic [7:0] digits;   // four 2-bit digits, first digit in [7:6]
        int         gap;      // idle cycles between digits
        logic [4:0] exp_res;
        logic       exp_err;
        bit         chain;    // assert start in the DONE cycle for the next entry
    } vec_t;

    vec_t tbl [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_conv(input logic [7:0] digs, input int gap, input logic [4:0] exp_res,
                           input logic exp_err, input bit chain_next, input bit started);
        if (!started) begin
            // A digit alongside start in IDLE must be ignored
            bus_if.start        = 1'b1;
            bus_if.digit_valid  = 1'b1;
            bus_if.digit_select = 2'b01;
            @(negedge clk);
        end
        bus_if.start       = 1'b0;
        bus_if.digit_valid = 1'b0;
        check("busy_after_start", {31'd0, bus_if.busy}, 32'd1);
        check("err_cleared_by_start", {31'd0, bus_if.digit_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus_if.digit_valid  = 1'b1;
            bus_if.digit_select = digs[7-2*i -: 2];
            @(negedge clk);
            bus_if.digit_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("busy_in_gap", {31'd0, bus_if.busy}, 32'd1);
                    check("no_valid_in_gap", {31'd0, bus_if.result_valid}, 32'd0);
                end
            end
        end
        check("result_valid", {31'd0, bus_if.result_valid}, 32'd1);
        check("result", {27'd0, bus_if.result}, {27'd0, exp_res});
        check("digit_err", {31'd0, bus_if.digit_err}, {31'd0, exp_err});
        check("busy_in_done", {31'd0, bus_if.busy}, 32'd0);
        if (chain_next) begin
            bus_if.start = 1'b1;
        end
        @(negedge clk);
        check("valid_single_pulse", {31'd0, bus_if.result_valid}, 32'd0);
        check("result_held", {27'd0, bus_if.result}, {27'd0, exp_res});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{digits: 8'b10_00_01_10, gap: 0, exp_res: 5'b00111, exp_err: 1'b0, chain: 1'b0};
        tbl[1] = '{digits: 8'b01_01_01_01, gap: 0, exp_res: 5'b10001, exp_err: 1'b0, chain: 1'b1};
        tbl[2] = '{digits: 8'b10_01_01_01, gap: 0, exp_res: 5'b00001, exp_err: 1'b0, chain: 1'b0};
        tbl[3] = '{digits: 8'b00_00_00_00, gap: 2, exp_res: 5'b00000, exp_err: 1'b0, chain: 1'b0};
        tbl[4] = '{digits: 8'b10_11_10_00, gap: 0, exp_res: 5'b01010, exp_err: 1'b1, chain: 1'b0};

        rst_n               = 1'b0;
        bus_if.start        = 1'b0;
        bus_if.digit_valid  = 1'b0;
        bus_if.digit_select = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check("reset_result", {27'd0, bus_if.result}, 32'd0);
        check("reset_err", {31'd0, bus_if.digit_err}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_conv(tbl[i].digits, tbl[i].gap, tbl[i].exp_res, tbl[i].exp_err,
                    tbl[i].chain, (i > 0) && tbl[i-1].chain);
        end

        // Abort: two digits (one illegal) then restart with a digit in the same cycle
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start        = 1'b0;
        bus_if.digit_valid  = 1'b1;
        bus_if.digit_select = 2'b10;
        @(negedge clk);
        bus_if.digit_select = 2'b11;
        @(negedge clk);
        check("err_set_partial", {31'd0, bus_if.digit_err}, 32'd1);
        bus_if.start        = 1'b1;
        bus_if.digit_select = 2'b10;
        @(negedge clk);
        check("abort_no_valid", {31'd0, bus_if.result_valid}, 32'd0);
        do_conv(8'b01_00_00_10, 0, 5'b11001, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-conversion
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start        = 1'b0;
        bus_if.digit_valid  = 1'b1;
        bus_if.digit_select = 2'b11;
        @(negedge clk);
        bus_if.digit_select = 2'b10;
        @(negedge clk);
        bus_if.digit_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", {31'd0, bus_if.busy}, 32'd0);
        check("async_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check("async_result", {27'd0, bus_if.result}, 32'd0);
        check("async_err", {31'd0, bus_if.digit_err}, 32'd0);
        @(negedge clk);
        rst_n               = 1'b1;
        bus_if.digit_valid  = 1'b1;
        bus_if.digit_select = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_ignores_busy", {31'd0, bus_if.busy}, 32'd0);
            check("idle_ignores_valid", {31'd0, bus_if.result_valid}, 32'd0);
        end
        bus_if.digit_valid = 1'b0;
        check("idle_result_zero", {27'd0, bus_if.result}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
